// File: rtl/pwm_regs_multi.sv
// Multi-channel PWM register file: byte-wide decoder bus, 16-bit atomic writes through a
// per-channel low-byte latch, shadow/active period and compare registers, sticky status with irq.
module pwm_regs_multi #(
  parameter int CH          = 4,
  parameter int CNT_W       = 16,
  parameter int RST_STRETCH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic                  write,
  input  logic [7:0]            addr,
  input  logic [7:0]            data_write,
  output logic [7:0]            data_read,
  input  logic [CH*CNT_W-1:0]   counter_val,
  input  logic [CH-1:0]         period_evt,
  input  logic [CH-1:0]         cmp_evt,
  output logic [CH*CNT_W-1:0]   period,
  output logic [CH*CNT_W-1:0]   compare1,
  output logic [CH*CNT_W-1:0]   compare2,
  output logic [CH*8-1:0]       prescale,
  output logic [CH*8-1:0]       functions,
  output logic [CH-1:0]         en,
  output logic [CH-1:0]         upnotdown,
  output logic [CH-1:0]         pwm_en,
  output logic [CH-1:0]         count_reset,
  output logic                  irq
);

  localparam logic [3:0] OFF_PER_L  = 4'h0;
  localparam logic [3:0] OFF_PER_H  = 4'h1;
  localparam logic [3:0] OFF_CMP1_L = 4'h2;
  localparam logic [3:0] OFF_CMP1_H = 4'h3;
  localparam logic [3:0] OFF_CMP2_L = 4'h4;
  localparam logic [3:0] OFF_CMP2_H = 4'h5;
  localparam logic [3:0] OFF_CTRL   = 4'h6;
  localparam logic [3:0] OFF_PRESC  = 4'h7;
  localparam logic [3:0] OFF_FUNC   = 4'h8;
  localparam logic [3:0] OFF_CNT_L  = 4'h9;
  localparam logic [3:0] OFF_CNT_H  = 4'hA;
  localparam logic [3:0] OFF_CNTRST = 4'hB;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  logic [3:0]         w_chan;
  logic [3:0]         w_off;
  logic [CH-1:0][7:0] w_rd_ch;
  logic [7:0]         w_rd_sel;
  logic [CH-1:0]      w_irq_src;
  logic [7:0]         r_data_read;
  logic               r_irq;

  assign w_chan = addr[7:4];
  assign w_off  = addr[3:0];

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [7:0]       r_latch;
    logic [CNT_W-1:0] r_per_sh, r_per_act;
    logic [CNT_W-1:0] r_cmp1_sh, r_cmp1_act;
    logic [CNT_W-1:0] r_cmp2_sh, r_cmp2_act;
    logic [4:0]       r_ctrl;
    logic [7:0]       r_prescale;
    logic [7:0]       r_functions;
    logic             r_ovf;
    logic             r_cmp;
    logic [3:0]       r_stretch;
    logic             w_wr;
    logic [15:0]      w_word;
    logic             w_clr_ovf;
    logic             w_clr_cmp;
    logic [15:0]      w_per16, w_cmp116, w_cmp216, w_cnt16;
    logic [7:0]       w_rd;

    // Out-of-range channel numbers never match any c, so their writes fall away here.
    assign w_wr      = write && (w_chan == 4'(c));
    assign w_word    = {data_write, r_latch};
    assign w_clr_ovf = w_wr && (w_off == OFF_STATUS) && data_write[0];
    assign w_clr_cmp = w_wr && (w_off == OFF_STATUS) && data_write[1];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_latch     <= '0;
        r_per_sh    <= '0;
        r_per_act   <= '0;
        r_cmp1_sh   <= '0;
        r_cmp1_act  <= '0;
        r_cmp2_sh   <= '0;
        r_cmp2_act  <= '0;
        r_ctrl      <= 5'b00010;
        r_prescale  <= '0;
        r_functions <= '0;
        r_ovf       <= 1'b0;
        r_cmp       <= 1'b0;
        r_stretch   <= '0;
      end else begin
        // Period event loads the active set; a disabled channel's commit below overrides it.
        if (period_evt[c]) begin
          r_per_act  <= r_per_sh;
          r_cmp1_act <= r_cmp1_sh;
          r_cmp2_act <= r_cmp2_sh;
        end
        if (w_wr) begin
          case (w_off)
            OFF_PER_L, OFF_CMP1_L, OFF_CMP2_L: r_latch <= data_write;
            OFF_PER_H: begin
              r_per_sh <= w_word[CNT_W-1:0];
              if (!r_ctrl[0]) r_per_act <= w_word[CNT_W-1:0];
            end
            OFF_CMP1_H: begin
              r_cmp1_sh <= w_word[CNT_W-1:0];
              if (!r_ctrl[0]) r_cmp1_act <= w_word[CNT_W-1:0];
            end
            OFF_CMP2_H: begin
              r_cmp2_sh <= w_word[CNT_W-1:0];
              if (!r_ctrl[0]) r_cmp2_act <= w_word[CNT_W-1:0];
            end
            OFF_CTRL:  r_ctrl      <= data_write[4:0];
            OFF_PRESC: r_prescale  <= data_write;
            OFF_FUNC:  r_functions <= data_write;
            default: ;
          endcase
        end
        r_ovf <= period_evt[c] | (r_ovf & ~w_clr_ovf);
        r_cmp <= cmp_evt[c] | (r_cmp & ~w_clr_cmp);
        if (w_wr && (w_off == OFF_CNTRST) && data_write[0]) begin
          r_stretch <= 4'(RST_STRETCH);
        end else if (r_stretch != 4'd0) begin
          r_stretch <= r_stretch - 4'd1;
        end
      end
    end

    always_comb begin
      w_per16  = '0;
      w_cmp116 = '0;
      w_cmp216 = '0;
      w_cnt16  = '0;
      w_per16[CNT_W-1:0]  = r_per_sh;
      w_cmp116[CNT_W-1:0] = r_cmp1_sh;
      w_cmp216[CNT_W-1:0] = r_cmp2_sh;
      w_cnt16[CNT_W-1:0]  = counter_val[c*CNT_W +: CNT_W];
      w_rd = 8'h00;
      case (w_off)
        OFF_PER_L:  w_rd = w_per16[7:0];
        OFF_PER_H:  w_rd = w_per16[15:8];
        OFF_CMP1_L: w_rd = w_cmp116[7:0];
        OFF_CMP1_H: w_rd = w_cmp116[15:8];
        OFF_CMP2_L: w_rd = w_cmp216[7:0];
        OFF_CMP2_H: w_rd = w_cmp216[15:8];
        OFF_CTRL:   w_rd = {3'b000, r_ctrl};
        OFF_PRESC:  w_rd = r_prescale;
        OFF_FUNC:   w_rd = r_functions;
        OFF_CNT_L:  w_rd = w_cnt16[7:0];
        OFF_CNT_H:  w_rd = w_cnt16[15:8];
        OFF_STATUS: w_rd = {6'd0, r_cmp, r_ovf};
        default:    w_rd = 8'h00;
      endcase
    end

    assign w_rd_ch[c]                 = w_rd;
    assign w_irq_src[c]               = (r_ovf & r_ctrl[3]) | (r_cmp & r_ctrl[4]);
    assign period[c*CNT_W +: CNT_W]   = r_per_act;
    assign compare1[c*CNT_W +: CNT_W] = r_cmp1_act;
    assign compare2[c*CNT_W +: CNT_W] = r_cmp2_act;
    assign prescale[c*8 +: 8]         = r_prescale;
    assign functions[c*8 +: 8]        = r_functions;
    assign en[c]                      = r_ctrl[0];
    assign upnotdown[c]               = r_ctrl[1];
    assign pwm_en[c]                  = r_ctrl[2];
    assign count_reset[c]             = (r_stretch != 4'd0);
  end

  always_comb begin
    w_rd_sel = 8'h00;
    for (int i = 0; i < CH; i++) begin
      if (w_chan == 4'(i)) w_rd_sel = w_rd_ch[i];
    end
  end

  // Read data reflects pre-edge state, so a same-cycle write is not yet visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_read <= 8'h00;
      r_irq       <= 1'b0;
    end else begin
      if (read) r_data_read <= w_rd_sel;
      r_irq <= |w_irq_src;
    end
  end

  assign data_read = r_data_read;
  assign irq       = r_irq;

endmodule

// File: tb/tb_pwm_regs_multi.sv
// Bench for pwm_regs_multi: directed register-map steps followed by random bus traffic,
// every cycle compared against a behavioural register-map model.
module tb_pwm_regs_multi;
  localparam int CH  = 4;
  localparam int RST = 3;

  logic          clk = 1'b0;
  logic          rst, read, write;
  logic [7:0]    addr, data_write, data_read;
  logic [63:0]   counter_val;
  logic [3:0]    period_evt, cmp_evt;
  logic [63:0]   period, compare1, compare2;
  logic [31:0]   prescale, functions;
  logic [3:0]    en, upnotdown, pwm_en, count_reset;
  logic          irq;

  logic          rd8, wr8;
  logic [7:0]    a8, d8, dr8;
  logic [31:0]   period8, compare1_8, compare2_8, prescale8, functions8;
  logic [3:0]    en8, ud8, pwm8, cr8;
  logic          irq8;

  always #5 clk = ~clk;

  pwm_regs_multi #(.CH(CH), .CNT_W(16), .RST_STRETCH(RST)) u_dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read), .counter_val(counter_val),
    .period_evt(period_evt), .cmp_evt(cmp_evt), .period(period),
    .compare1(compare1), .compare2(compare2), .prescale(prescale),
    .functions(functions), .en(en), .upnotdown(upnotdown), .pwm_en(pwm_en),
    .count_reset(count_reset), .irq(irq)
  );

  pwm_regs_multi #(.CH(CH), .CNT_W(8), .RST_STRETCH(RST)) u_dut8 (
    .clk(clk), .rst(rst), .read(rd8), .write(wr8), .addr(a8),
    .data_write(d8), .data_read(dr8), .counter_val(32'd0),
    .period_evt(4'd0), .cmp_evt(4'd0), .period(period8),
    .compare1(compare1_8), .compare2(compare2_8), .prescale(prescale8),
    .functions(functions8), .en(en8), .upnotdown(ud8), .pwm_en(pwm8),
    .count_reset(cr8), .irq(irq8)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] m_per_sh[CH], m_per_act[CH], m_c1_sh[CH], m_c1_act[CH], m_c2_sh[CH], m_c2_act[CH];
  logic [7:0]  m_latch[CH], m_pre[CH], m_fn[CH];
  logic [4:0]  m_ctrl[CH];
  logic        m_ovf[CH], m_cmpf[CH];
  int          cr_start[CH];
  logic [7:0]  m_dr;
  logic        m_irq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_per_sh[c] = 0; m_per_act[c] = 0; m_c1_sh[c] = 0; m_c1_act[c] = 0;
      m_c2_sh[c] = 0; m_c2_act[c] = 0; m_latch[c] = 0; m_pre[c] = 0; m_fn[c] = 0;
      m_ctrl[c] = 5'b00010; m_ovf[c] = 0; m_cmpf[c] = 0; cr_start[c] = -100;
    end
    m_dr  = 0;
    m_irq = 0;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int c, o;
    c = int'(a[7:4]);
    o = int'(a[3:0]);
    if (c >= CH) return 8'h00;
    case (o)
      0: return m_per_sh[c][7:0];
      1: return m_per_sh[c][15:8];
      2: return m_c1_sh[c][7:0];
      3: return m_c1_sh[c][15:8];
      4: return m_c2_sh[c][7:0];
      5: return m_c2_sh[c][15:8];
      6: return {3'b000, m_ctrl[c]};
      7: return m_pre[c];
      8: return m_fn[c];
      9: return counter_val[c*16 +: 8];
      10: return counter_val[c*16+8 +: 8];
      12: return {6'd0, m_cmpf[c], m_ovf[c]};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                            input logic [3:0] pe, input logic [3:0] ce);
    int c, o;
    logic [15:0] v;
    logic irq_n;
    logic [3:0] clr_o, clr_c;
    cyc++;
    if (r) m_dr = m_read(a);
    irq_n = 0;
    for (int k = 0; k < CH; k++) irq_n |= (m_ovf[k] & m_ctrl[k][3]) | (m_cmpf[k] & m_ctrl[k][4]);
    m_irq = irq_n;
    for (int k = 0; k < CH; k++) begin
      if (pe[k]) begin
        m_per_act[k] = m_per_sh[k]; m_c1_act[k] = m_c1_sh[k]; m_c2_act[k] = m_c2_sh[k];
      end
    end
    clr_o = 0;
    clr_c = 0;
    c = int'(a[7:4]);
    o = int'(a[3:0]);
    if (w && c < CH) begin
      v = {d, m_latch[c]};
      case (o)
        0, 2, 4: m_latch[c] = d;
        1: begin m_per_sh[c] = v; if (!m_ctrl[c][0]) m_per_act[c] = v; end
        3: begin m_c1_sh[c] = v;  if (!m_ctrl[c][0]) m_c1_act[c] = v; end
        5: begin m_c2_sh[c] = v;  if (!m_ctrl[c][0]) m_c2_act[c] = v; end
        6: m_ctrl[c] = d[4:0];
        7: m_pre[c] = d;
        8: m_fn[c] = d;
        11: if (d[0]) cr_start[c] = cyc;
        12: begin clr_o[c] = d[0]; clr_c[c] = d[1]; end
        default: ;
      endcase
    end
    for (int k = 0; k < CH; k++) begin
      m_ovf[k]  = pe[k] | (m_ovf[k] & !clr_o[k]);
      m_cmpf[k] = ce[k] | (m_cmpf[k] & !clr_c[k]);
    end
  endtask

  task automatic check_all();
    logic [63:0] e_per, e_c1, e_c2;
    logic [31:0] e_pre, e_fn;
    logic [3:0]  e_en, e_ud, e_pwm, e_cr;
    for (int c = 0; c < CH; c++) begin
      e_per[c*16 +: 16] = m_per_act[c];
      e_c1[c*16 +: 16]  = m_c1_act[c];
      e_c2[c*16 +: 16]  = m_c2_act[c];
      e_pre[c*8 +: 8]   = m_pre[c];
      e_fn[c*8 +: 8]    = m_fn[c];
      e_en[c]  = m_ctrl[c][0];
      e_ud[c]  = m_ctrl[c][1];
      e_pwm[c] = m_ctrl[c][2];
      e_cr[c]  = (cyc >= cr_start[c]) && (cyc < cr_start[c] + RST);
    end
    check("data_read", {56'd0, data_read}, {56'd0, m_dr});
    check("irq", {63'd0, irq}, {63'd0, m_irq});
    check("period", period, e_per);
    check("compare1", compare1, e_c1);
    check("compare2", compare2, e_c2);
    check("presc_func", {prescale, functions}, {e_pre, e_fn});
    check("ctrl_bits", {48'd0, en, upnotdown, pwm_en, count_reset}, {48'd0, e_en, e_ud, e_pwm, e_cr});
  endtask

  task automatic step(input logic rs, input logic r, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic [3:0] pe, input logic [3:0] ce);
    rst = rs; read = r; write = w; addr = a; data_write = d; period_evt = pe; cmp_evt = ce;
    counter_val = {$urandom, $urandom};
    @(posedge clk);
    if (rs) model_reset();
    else model_step(r, w, a, d, pe, ce);
    #1;
    check_all();
    rst = 0; read = 0; write = 0; period_evt = '0; cmp_evt = '0;
  endtask

  task automatic nop();                                  step(0, 0, 0, 8'h00, 8'h00, 4'h0, 4'h0); endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d); step(0, 0, 1, a, d, 4'h0, 4'h0); endtask
  task automatic rd(input logic [7:0] a);                step(0, 1, 0, a, 8'h00, 4'h0, 4'h0); endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; read = 0; write = 0; addr = 0; data_write = 0; period_evt = 0; cmp_evt = 0;
    counter_val = 0; rd8 = 0; wr8 = 0; a8 = 0; d8 = 0;
    model_reset();
    step(1, 0, 0, 8'h00, 8'h00, 4'h0, 4'h0);
    step(1, 0, 0, 8'h00, 8'h00, 4'h0, 4'h0);

    // Channel 0 register map right after reset.
    for (int o = 0; o < 16; o++) begin
      rd(8'(o));
      if (o == 6) check("rst_ctrl", {56'd0, data_read}, 64'h02);
    end
    check("rst_irq", {63'd0, irq}, 64'd0);

    // Disabled channel: commit lands immediately, low byte alone does nothing.
    wr(8'h10, 8'h34);
    check("per1_after_L", {48'd0, period[31:16]}, 64'h0);
    wr(8'h11, 8'h12);
    check("per1_commit", {48'd0, period[31:16]}, 64'h1234);
    rd(8'h11);
    check("per1_read_H", {56'd0, data_read}, 64'h12);

    // Enabled channel: active waits for the period event.
    wr(8'h26, 8'h01);
    wr(8'h22, 8'h00);
    wr(8'h23, 8'h01);
    check("cmp1_held", {48'd0, compare1[47:32]}, 64'h0);
    rd(8'h22);
    check("cmp1_L_shadow", {56'd0, data_read}, 64'h00);
    rd(8'h23);
    check("cmp1_H_shadow", {56'd0, data_read}, 64'h01);
    step(0, 0, 0, 8'h00, 8'h00, 4'b0100, 4'h0);
    check("cmp1_after_evt", {48'd0, compare1[47:32]}, 64'h0100);

    // Count reset stretch and restart.
    wr(8'h3B, 8'h00);
    check("cntrst_b0_zero", {63'd0, count_reset[3]}, 64'd0);
    wr(8'h3B, 8'h01);
    nop();
    wr(8'h3B, 8'h01);
    nop();
    nop();
    check("cntrst_cycle5", {63'd0, count_reset[3]}, 64'd1);
    nop();
    check("cntrst_end", {63'd0, count_reset[3]}, 64'd0);
    rd(8'h3B);
    check("cntrst_reads0", {56'd0, data_read}, 64'h00);

    // Status, irq, set-beats-clear.
    wr(8'h06, 8'h08);
    step(0, 0, 0, 8'h00, 8'h00, 4'b0001, 4'h0);
    rd(8'h0C);
    check("status_ovf", {56'd0, data_read}, 64'h01);
    check("irq_set", {63'd0, irq}, 64'd1);
    step(0, 0, 1, 8'h0C, 8'h01, 4'b0001, 4'h0);
    rd(8'h0C);
    check("status_set_wins", {56'd0, data_read}, 64'h01);
    wr(8'h0C, 8'h01);
    nop();
    check("irq_cleared", {63'd0, irq}, 64'd0);

    // Random traffic, including out-of-range channels 4 and 5.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      logic [3:0] pe, ce;
      a  = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 15))};
      pe = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      ce = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step($urandom_range(0, 149) == 0, 1'($urandom), 1'($urandom), a, 8'($urandom), pe, ce);
    end

    // Narrow-counter build: high byte truncated, out-of-range channel inert.
    step(1, 0, 0, 8'h00, 8'h00, 4'h0, 4'h0);
    wr8 = 1; a8 = 8'h00; d8 = 8'hAB; nop();
    a8 = 8'h01; d8 = 8'hFF; nop();
    wr8 = 0;
    check("w8_period", {32'd0, period8}, 64'h0000_00AB);
    rd8 = 1; a8 = 8'h01; nop();
    check("w8_read_H", {56'd0, dr8}, 64'h00);
    a8 = 8'h00; nop();
    rd8 = 0;
    check("w8_read_L", {56'd0, dr8}, 64'hAB);
    wr8 = 1; a8 = 8'hF0; d8 = 8'h55; nop();
    a8 = 8'hF1; d8 = 8'h66; nop();
    a8 = 8'hF6; d8 = 8'h07; nop();
    wr8 = 0;
    check("w8_badch_period", {32'd0, period8}, 64'h0000_00AB);
    check("w8_badch_ctrl", {60'd0, en8}, 64'd0);
    rd8 = 1; a8 = 8'hF0; nop();
    rd8 = 0;
    check("w8_badch_read", {56'd0, dr8}, 64'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
